// File: rtl/data_memory_pkg.sv
// data_memory_pkg: command codes, MMIO offsets and command classification helpers.
package data_memory_pkg;
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd9,
    MEM_SH   = 4'd10,
    MEM_SW   = 4'd11
  } mem_cmd_e;
  localparam logic [1:0] OFF_CYCLE_LO  = 2'd0;
  localparam logic [1:0] OFF_CYCLE_HI  = 2'd1;
  localparam logic [1:0] OFF_STORE_CNT = 2'd2;
  localparam logic [1:0] OFF_TOHOST    = 2'd3;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic FALSE = 1'b0;
  function automatic logic is_load(input logic [3:0] c);
    return c inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction
  function automatic logic is_store(input logic [3:0] c);
    return c inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: MEM-stage request bus plus the memory's status outputs.
interface data_memory_if;
  logic [31:0] MEM_mem_addr;
  logic [3:0]  MEM_mem_cmd;
  logic [31:0] MEM_mem_din;
  logic [31:0] DM_mem_dout;
  logic        DM_fault;
  logic [31:0] DM_fault_addr;
  logic        DM_halt;
  logic [31:0] DM_tohost;
  modport master(
    output MEM_mem_addr, MEM_mem_cmd, MEM_mem_din,
    input  DM_mem_dout, DM_fault, DM_fault_addr, DM_halt, DM_tohost
  );
  modport slave(
    input  MEM_mem_addr, MEM_mem_cmd, MEM_mem_din,
    output DM_mem_dout, DM_fault, DM_fault_addr, DM_halt, DM_tohost
  );
endinterface

// File: rtl/data_memory_mmio.sv
// dm_mmio: cycle counter with hi snapshot, committed-store counter and tohost halt register.
module dm_mmio
  import data_memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic        st_inc_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        halt_o,
  output logic [31:0] tohost_o
);
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] snap_q, snap_d, cnt_q, cnt_d, tohost_q, tohost_d;
  logic        halt_q, halt_d, th_wr;
  always_comb begin
    th_wr    = wr_en_i && off_i == OFF_TOHOST;
    cycle_d  = cycle_q + 64'd1;
    snap_d   = (rd_en_i && off_i == OFF_CYCLE_LO) ? cycle_q[63:32] : snap_q;
    cnt_d    = cnt_q + {31'd0, st_inc_i};
    halt_d   = halt_q | th_wr;
    tohost_d = (th_wr && !halt_q) ? wdata_i : tohost_q;
    rdata_o  = !rd_en_i                  ? 32'd0 :
               off_i == OFF_CYCLE_LO     ? cycle_q[31:0] :
               off_i == OFF_CYCLE_HI     ? snap_q :
               off_i == OFF_STORE_CNT    ? cnt_q : 32'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q  <= '0;
      snap_q   <= '0;
      cnt_q    <= '0;
      halt_q   <= FALSE;
      tohost_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      halt_q   <= halt_d;
      tohost_q <= tohost_d;
    end
  end
  assign halt_o   = halt_q;
  assign tohost_o = tohost_q;
endmodule

// File: rtl/data_memory.sv
// data_memory: byte-lane RAM with formatted zero-latency loads, misalignment capture and an MMIO window.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input logic clk,
  input logic rst,
  data_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] a, word, fmt, wdata, mmio_rdata, fault_addr_q, fault_addr_d;
  logic [3:0]  c, be;
  logic [7:0]  b;
  logic [15:0] h;
  logic        mmio, half, full, misal, ram_ld, ram_st, mmio_rd, mmio_wr, fault_q, fault_d;
  always_comb begin
    a       = bus.MEM_mem_addr;
    c       = bus.MEM_mem_cmd;
    mmio    = a[31:4] == MMIO_BASE[31:4];
    half    = c inside {MEM_LH, MEM_LHU, MEM_SH};
    full    = c inside {MEM_LW, MEM_SW};
    // Sub-word MMIO accesses are silently ignored rather than treated as faults
    misal   = (full && a[1:0] != 2'd0) || (half && a[0] && !mmio);
    ram_ld  = is_load(c) && !mmio && !misal;
    ram_st  = is_store(c) && !mmio && !misal;
    mmio_rd = mmio && c == MEM_LW && !misal;
    mmio_wr = mmio && c == MEM_SW && !misal;
    word    = mem_q[a[AW+1:2]];
    b       = word[{a[1:0], 3'b000} +: 8];
    h       = word[{a[1], 4'b0000} +: 16];
    fmt     = c == MEM_LB  ? {{24{b[7]}}, b} :
              c == MEM_LBU ? {24'd0, b} :
              c == MEM_LH  ? {{16{h[15]}}, h} :
              c == MEM_LHU ? {16'd0, h} : word;
    be      = c == MEM_SB ? 4'b0001 << a[1:0] :
              c == MEM_SH ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    wdata   = c == MEM_SB ? {4{bus.MEM_mem_din[7:0]}} :
              c == MEM_SH ? {2{bus.MEM_mem_din[15:0]}} : bus.MEM_mem_din;
    fault_d      = fault_q | misal;
    fault_addr_d = (misal && !fault_q) ? a : fault_addr_q;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_st && !rst && be[i]) mem_q[a[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q      <= FALSE;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end
  dm_mmio u_mmio (
    .clk      (clk),
    .rst      (rst),
    .rd_en_i  (mmio_rd),
    .wr_en_i  (mmio_wr),
    .st_inc_i (ram_st || mmio_wr),
    .off_i    (a[3:2]),
    .wdata_i  (bus.MEM_mem_din),
    .rdata_o  (mmio_rdata),
    .halt_o   (bus.DM_halt),
    .tohost_o (bus.DM_tohost)
  );
  assign bus.DM_mem_dout   = ram_ld ? fmt : mmio_rd ? mmio_rdata : 32'd0;
  assign bus.DM_fault      = fault_q;
  assign bus.DM_fault_addr = fault_addr_q;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench; expected load data is queued at drive time and popped mid-cycle.
module tb_data_memory;
  import data_memory_pkg::*;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  data_memory_if bus ();
  data_memory #(.DEPTH_WORDS(4096), .MMIO_BASE(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // Entered at posedge+1; drives one request, samples load data mid-cycle, returns at the next posedge+1.
  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                    input bit ld, input logic [31:0] e, input string tag);
    bus.MEM_mem_cmd  = c;
    bus.MEM_mem_addr = a;
    bus.MEM_mem_din  = d;
    if (ld) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    if (ld) check(tag_q.pop_front(), bus.DM_mem_dout, exp_q.pop_front());
    @(posedge clk);
    #1;
    bus.MEM_mem_cmd = MEM_NONE;
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    bus.MEM_mem_cmd  = MEM_NONE;
    bus.MEM_mem_addr = '0;
    bus.MEM_mem_din  = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", bus.DM_mem_dout, 32'd0);
    check("rst_fault", {31'd0, bus.DM_fault}, 32'd0);
    check("rst_faddr", bus.DM_fault_addr, 32'd0);
    check("rst_halt", {31'd0, bus.DM_halt}, 32'd0);
    check("rst_tohost", bus.DM_tohost, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    op(MEM_LW, BASE, 0, 1, 32'd9, "cycle9");
    op(MEM_SW, 32'h10, 32'h8899_AABB, 0, 0, "");
    op(MEM_LB, 32'h12, 0, 1, 32'hFFFF_FF99, "lb");
    op(MEM_LBU, 32'h12, 0, 1, 32'h0000_0099, "lbu");
    op(MEM_LH, 32'h10, 0, 1, 32'hFFFF_AABB, "lh");
    op(MEM_LHU, 32'h10, 0, 1, 32'h0000_AABB, "lhu");
    op(MEM_LW, 32'h10, 0, 1, 32'h8899_AABB, "lw");
    op(MEM_LB, 32'h11, 0, 1, 32'hFFFF_FFAA, "lb1");
    op(MEM_LBU, 32'h13, 0, 1, 32'h0000_0088, "lbu3");
    op(MEM_LH, 32'h12, 0, 1, 32'hFFFF_8899, "lh2");
    rst_pulse();
    op(MEM_SW, 32'h20, 32'h0, 0, 0, "");
    op(MEM_SB, 32'h21, 32'h1234_56AB, 0, 0, "");
    op(MEM_SH, 32'h22, 32'hCAFE_BEEF, 0, 0, "");
    op(MEM_LW, 32'h20, 0, 1, 32'hBEEF_AB00, "st_merge");
    op(MEM_LW, BASE + 32'h8, 0, 1, 32'd3, "stcnt3");
    op(MEM_SW, 32'h104, 32'h5566_7788, 0, 0, "");
    op(MEM_LW, 32'h102, 0, 1, 32'd0, "misal_lw");
    check("fault", {31'd0, bus.DM_fault}, 32'd1);
    check("faddr", bus.DM_fault_addr, 32'h102);
    op(MEM_SH, 32'h105, 32'hDEAD, 0, 0, "");
    check("faddr_keep", bus.DM_fault_addr, 32'h102);
    op(MEM_LW, 32'h104, 0, 1, 32'h5566_7788, "misal_sh_ram");
    op(MEM_LW, BASE + 32'h8, 0, 1, 32'd4, "stcnt_misal");
    force dut.u_mmio.cycle_q = 64'h0000_0000_FFFF_FFFF;
    op(MEM_LW, BASE, 0, 1, 32'hFFFF_FFFF, "cyc_lo");
    release dut.u_mmio.cycle_q;
    op(MEM_LW, BASE + 32'h4, 0, 1, 32'd0, "cyc_hi_snap");
    rst_pulse();
    op(MEM_SW, BASE + 32'hC, 32'h1, 0, 0, "");
    check("halt1", {31'd0, bus.DM_halt}, 32'd1);
    check("tohost1", bus.DM_tohost, 32'h1);
    op(MEM_SW, BASE + 32'hC, 32'h7, 0, 0, "");
    check("halt2", {31'd0, bus.DM_halt}, 32'd1);
    check("tohost2", bus.DM_tohost, 32'h1);
    op(MEM_LW, BASE + 32'h8, 0, 1, 32'd2, "stcnt_tohost");
    op(MEM_LW, BASE + 32'hC, 0, 1, 32'd0, "tohost_rd");
    op(MEM_LB, BASE + 32'h8, 0, 1, 32'd0, "mmio_lb");
    check("mmio_lb_nofault", {31'd0, bus.DM_fault}, 32'd0);
    op(MEM_SW, 32'h4000, 32'h5A, 0, 0, "");
    op(MEM_LW, 32'h0, 0, 1, 32'h5A, "wrap");
    op(MEM_SW, 32'h30, 32'h11, 0, 0, "");
    op(MEM_LH, 32'h31, 0, 1, 32'd0, "misal_lh");
    check("fault_pre", {31'd0, bus.DM_fault}, 32'd1);
    bus.MEM_mem_cmd  = MEM_SW;
    bus.MEM_mem_addr = 32'h30;
    bus.MEM_mem_din  = 32'h22;
    #3 rst = 1'b1;
    #1;
    check("mid_fault", {31'd0, bus.DM_fault}, 32'd0);
    check("mid_faddr", bus.DM_fault_addr, 32'd0);
    check("mid_halt", {31'd0, bus.DM_halt}, 32'd0);
    check("mid_tohost", bus.DM_tohost, 32'd0);
    check("mid_dout", bus.DM_mem_dout, 32'd0);
    @(posedge clk);
    #1;
    bus.MEM_mem_cmd = MEM_NONE;
    rst = 1'b0;
    op(MEM_LW, 32'h30, 0, 1, 32'h11, "mid_nostore");
    op(MEM_LW, BASE + 32'h8, 0, 1, 32'd0, "mid_stcnt");
    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Data-side memory responder for the five-stage pipeline: it services the MEM-stage request (`MEM_mem_addr`, `MEM_mem_cmd`, `MEM_mem_din`) and returns `DM_mem_dout` in the same cycle. It contains:
- a word-organised RAM with byte-lane stores;
- load formatting (sign/zero extension);
- misalignment fault detection;
- a small MMIO window with a cycle counter, a store counter and a `tohost` halt register.

It instantiates next to the processor in the system top.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'hFFFF_0000: base of the 16-byte MMIO window; bits [3:0] are zero.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `MEM_mem_addr` in 32: byte address.
- `MEM_mem_cmd` in 4: `MEM_NONE`=0, `MEM_LB`=1, `MEM_LH`=2, `MEM_LW`=3, `MEM_LBU`=4, `MEM_LHU`=5, `MEM_SB`=9, `MEM_SH`=10, `MEM_SW`=11. Other codes are treated as `MEM_NONE`.
- `MEM_mem_din` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `DM_mem_dout` out 32: formatted load data, combinational.
- `DM_fault` out 1: sticky misalignment flag.
- `DM_fault_addr` out 32: address of the first faulting access.
- `DM_halt` out 1: sticky, set by a write to `tohost`.
- `DM_tohost` out 32: value of the first `tohost` write.

## Operation
Address decode:
- **MMIO hit:** `addr[31:4] == MMIO_BASE[31:4]`.
- **Otherwise RAM:** word index = `addr[log2(DEPTH_WORDS)+1:2]`. Higher bits are ignored, so RAM accesses wrap modulo the depth.

Alignment and faults:
- Half accesses require `addr[0]=0`; word accesses require `addr[1:0]=0`.
- A misaligned load returns 0. A misaligned store is suppressed: no RAM, MMIO or counter update.
- A misaligned access sets `DM_fault`. `DM_fault_addr` captures the address only if `DM_fault` was 0.

Loads (RAM):
- The lane is selected by `addr[1:0]`.
- `LB`/`LH` sign-extend; `LBU`/`LHU` zero-extend; `LW` passes the word through.
- `DM_mem_dout`=0 whenever the cmd is not a load.

Stores (RAM):
- `SB` writes byte lane `addr[1:0]` with `din[7:0]`.
- `SH` writes lanes {`addr[1]`*2, +1} with `din[15:0]`.
- `SW` writes all four lanes.

MMIO registers (offsets 0x0, 0x4, 0x8, 0xC):
- **0x0 `CYCLE_LO`, RO:**
  - A word read returns `cycle[31:0]`.
  - The same read latches `cycle[63:32]` into the shadow register `cyc_hi_snap` at the clock edge.
- **0x4 `CYCLE_HI`, RO:** returns `cyc_hi_snap`.
- **0x8 `STORE_CNT`, RO:** number of committed non-faulting stores (RAM and MMIO), 32-bit wrapping.
- **0xC `TOHOST`, WO:**
  - An `SW` sets `DM_halt`.
  - On the first write only, the data is captured into `DM_tohost`. Later writes still count in `STORE_CNT` but do not change `DM_tohost`.
- MMIO rules:
  - Only `LW`/`SW` are legal in the window. Byte or half MMIO accesses return 0 and are ignored; they are not faults.
  - Reads of `TOHOST` return 0. Writes to RO offsets are ignored but counted.

Counters:
- `cycle` is 64-bit: 0 in the first cycle after reset release, +1 every cycle, wraps.
- `DM_halt` does not freeze any counter or the RAM.

## Timing
- Load latency: 0 cycles, with `DM_mem_dout` combinational from address, cmd and array.
- Store commit: at the posedge ending the request cycle. A load in the next cycle observes the new data.
- Flag update: `DM_fault`, `DM_fault_addr`, `DM_halt`, `DM_tohost` and `STORE_CNT` update at the posedge ending the request cycle.
- `CYCLE_LO` read value: the pre-increment value of that cycle.
- Reset values:
  - All outputs 0; `cycle`, `cyc_hi_snap` and `STORE_CNT` are 0.
  - RAM contents are not cleared; the bench preloads them via `$readmemh`.
- Reset asserted mid-operation clears all flags and counters immediately (asynchronous). A store in that cycle is discarded.

## Structure
- `sys_defs.vh` holds:
  - the `MEM_*` command codes;
  - the MMIO offset constants;
  - `ZERO_REG` and `FALSE` as already defined.
- One sub-module, `dm_mmio`, owns the 64-bit cycle counter, `cyc_hi_snap`, `STORE_CNT` and the `tohost`/halt logic.
- `data_memory` owns decode, alignment check, RAM, lane formatting and the fault capture.

## Test plan
- RAM preloaded word 0x10 = 32'h8899_AABB:
  - `LB` 0x12 -> 32'hFFFF_FF99; `LBU` 0x12 -> 32'h0000_0099.
  - `LH` 0x10 -> 32'hFFFF_AABB; `LW` 0x10 -> 32'h8899_AABB.
- Stores, then `LW` 0x20 in the next cycle:
  - `SW` 0x20 32'h0; `SB` 0x21 32'h1234_56AB; `SH` 0x22 32'hCAFE_BEEF.
  - Required: `LW` 0x20 -> 32'hBEEF_AB00; `STORE_CNT` read -> 3.
- Misalignment:
  - `LW` 0x102 -> dout 0, `DM_fault`=1, `DM_fault_addr`=0x102.
  - Then `SH` 0x105 -> RAM unchanged, `DM_fault_addr` stays 0x102, `STORE_CNT` unchanged.
- Cycle counter: reset, then 9 idle cycles, then `LW` `MMIO_BASE` -> 9.
  - Force `cycle`=32'hFFFF_FFFF low with hi=0; read `LO` -> 32'hFFFF_FFFF; next-cycle read `HI` -> 0 (snapshot, not 1).
- Tohost: `SW` `MMIO_BASE`+0xC 32'h1, then 32'h7 -> `DM_halt`=1 and `DM_tohost`=1 after the first edge; both unchanged after the second; `STORE_CNT`=2.
- Wrap and reset:
  - With `DEPTH_WORDS`=4096, `SW` 0x4000 32'h5A -> `LW` 0x0 returns 32'h5A.
  - Assert `rst` mid-`SW` -> all outputs 0 immediately, store not committed.
